// File: rtl/ahb2apb_pkg.sv
// Shared constants and helpers for the parametrised AHB-Lite to APB4 bridge.
package ahb2apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Bridge state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    // Byte strobes for a transfer of the given size at the given address
    // low bits; the caller keeps the lower dw/8 bits of the result.
    function automatic logic [7:0] strb_f(input logic [2:0] size,
                                          input logic [2:0] lsbs,
                                          input int unsigned dw);
        logic [2:0] off;
        logic [7:0] strb;
        off = lsbs & ((dw == 32'd64) ? 3'b111 : 3'b011);
        case (size)
            HSIZE_BYTE:  strb = 8'b0000_0001 << off;
            HSIZE_HALF:  strb = 8'b0000_0011 << {off[2:1], 1'b0};
            HSIZE_WORD:  strb = (dw == 32'd64) ? (8'b0000_1111 << {off[2], 2'b00})
                                               : 8'b0000_1111;
            HSIZE_DWORD: strb = 8'b1111_1111;
            default:     strb = 8'b0000_0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ahb2apb_decode.sv
// Combinational slave decode: window hit, slave index, size and alignment check.
module ahb2apb_decode
    import ahb2apb_pkg::*;
#(
    parameter int             AW        = 32,
    parameter int             DW        = 32,
    parameter int             NSLV      = 3,
    parameter logic [AW-1:0]  BASE_ADDR = AW'(32'h8000_0000),
    parameter int             SLV_SHIFT = 12
) (
    input  logic [AW-1:0] haddr,
    input  logic [2:0]    hsize,
    output logic [2:0]    idx,
    output logic          legal
);

    // Largest size the data bus can carry in one beat
    localparam logic [2:0] MAX_SIZE = (DW == 64) ? HSIZE_DWORD : HSIZE_WORD;

    logic hit_s;
    logic size_ok_s;
    logic aligned_s;
    logic unused_s;

    assign idx       = haddr[SLV_SHIFT +: 3];
    assign hit_s     = (haddr[AW-1:SLV_SHIFT+3] == BASE_ADDR[AW-1:SLV_SHIFT+3])
                       && (32'(idx) < 32'(NSLV));
    assign size_ok_s = (hsize <= MAX_SIZE);
    assign legal     = hit_s & size_ok_s & aligned_s;
    assign unused_s  = ^haddr;

    // Address must be a multiple of the transfer size
    always_comb begin
        case (hsize)
            HSIZE_BYTE:  aligned_s = 1'b1;
            HSIZE_HALF:  aligned_s = (haddr[0] == 1'b0);
            HSIZE_WORD:  aligned_s = (haddr[1:0] == 2'b00);
            HSIZE_DWORD: aligned_s = (haddr[2:0] == 3'b000);
            default:     aligned_s = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahb2apb_bridge_p.sv
// Parametrised AHB-Lite to APB4 bridge, one outstanding transfer at a time.
module ahb2apb_bridge_p
    import ahb2apb_pkg::*;
#(
    parameter int             AW        = 32,
    parameter int             DW        = 32,
    parameter int             NSLV      = 3,
    parameter logic [AW-1:0]  BASE_ADDR = AW'(32'h8000_0000),
    parameter int             SLV_SHIFT = 12,
    parameter int             TIMEOUT   = 255
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic [1:0]        Htrans,
    input  logic              Hwrite,
    input  logic [2:0]        Hsize,
    input  logic [AW-1:0]     Haddr,
    input  logic [DW-1:0]     Hwdata,
    input  logic              Hreadyin,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DW-1:0]     Hrdata,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [AW-1:0]     Paddr,
    output logic [DW-1:0]     Pwdata,
    output logic [DW/8-1:0]   Pstrb,
    input  logic              Pready,
    input  logic              Pslverr,
    input  logic [DW-1:0]     Prdata
);

    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [2:0]      state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [2:0]      idx_q,       idx_d;
    logic            hreadyout_q, hreadyout_d;
    logic [1:0]      hresp_q,     hresp_d;
    logic [DW-1:0]   hrdata_q,    hrdata_d;
    logic [NSLV-1:0] pselx_q,     pselx_d;
    logic            penable_q,   penable_d;
    logic            pwrite_q,    pwrite_d;
    logic [AW-1:0]   paddr_q,     paddr_d;
    logic [DW-1:0]   pwdata_q,    pwdata_d;
    logic [SW-1:0]   pstrb_q,     pstrb_d;

    logic            htrans_act_s;
    logic            accept_s;
    logic [2:0]      dec_idx_s;
    logic            dec_legal_s;
    logic [7:0]      strb8_s;
    logic [CW-1:0]   cnt_sat_s;
    logic            timeout_s;
    logic            unused_strb_s;

    ahb2apb_decode #(
        .AW        (AW),
        .DW        (DW),
        .NSLV      (NSLV),
        .BASE_ADDR (BASE_ADDR),
        .SLV_SHIFT (SLV_SHIFT)
    ) u_decode (
        .haddr (Haddr),
        .hsize (Hsize),
        .idx   (dec_idx_s),
        .legal (dec_legal_s)
    );

    // Only NONSEQ and SEQ start a transfer; IDLE and BUSY are ignored
    always_comb begin
        case (Htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: htrans_act_s = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  htrans_act_s = 1'b0;
            default:                   htrans_act_s = 1'b0;
        endcase
    end

    // Hreadyout is high only in IDLE and ERR2, so acceptance is limited to those
    assign accept_s      = Hreadyin & hreadyout_q & htrans_act_s;
    assign strb8_s       = strb_f(Hsize, Haddr[2:0], 32'(DW));
    assign unused_strb_s = ^strb8_s;
    assign cnt_sat_s     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    assign timeout_s     = (TIMEOUT != 32'sd0) && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));

    // Next-state, APB control and registered AHB response computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hrdata_d = hrdata_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (!dec_legal_s) begin
                    state_d = ST_ERR1;
                end else if (Hwrite) begin
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_WDATA: begin
                state_d  = ST_SETUP;
                pwdata_d = Hwdata;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = {CW{1'b0}};
            end
            ST_ACCESS: begin
                if (Pready && Pslverr) begin
                    state_d = ST_ERR1;
                end else if (Pready) begin
                    state_d = ST_IDLE;
                    if (!pwrite_q) begin
                        hrdata_d = Prdata;
                    end else begin
                        hrdata_d = hrdata_q;
                    end
                end else if (timeout_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_ACCESS;
                    cnt_d   = cnt_sat_s;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // Address-phase attributes are captured on every accepted transfer
        if (accept_s) begin
            idx_d    = dec_idx_s;
            paddr_d  = Haddr;
            pwrite_d = Hwrite;
            pstrb_d  = Hwrite ? strb8_s[SW-1:0] : {SW{1'b0}};
        end else begin
            idx_d    = idx_q;
        end

        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        penable_d   = (state_d == ST_ACCESS);
        for (int i = 0; i < NSLV; i++) begin
            pselx_d[i] = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) && (idx_d == 3'(i));
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            idx_q       <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= {DW{1'b0}};
            pselx_q     <= {NSLV{1'b0}};
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= {AW{1'b0}};
            pwdata_q    <= {DW{1'b0}};
            pstrb_q     <= {SW{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    assign Hreadyout = hreadyout_q;
    assign Hresp     = hresp_q;
    assign Hrdata    = hrdata_q;
    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pstrb     = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
// Self-checking bench for ahb2apb_bridge_p (AW=32, DW=32, NSLV=3, TIMEOUT=4).
module tb_ahb2apb_bridge_p;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [3:0]  Pstrb;
    logic        Pready;
    logic        Pslverr;
    logic [31:0] Prdata;

    always #5 Hclk = ~Hclk;

    ahb2apb_bridge_p #(
        .AW(32), .DW(32), .NSLV(3), .BASE_ADDR(32'h8000_0000), .SLV_SHIFT(12), .TIMEOUT(4)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout),
        .Hresp(Hresp), .Hrdata(Hrdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Pstrb(Pstrb), .Pready(Pready), .Pslverr(Pslverr),
        .Prdata(Prdata)
    );

    int total = 0;
    int bad   = 0;

    // reference-model memory of what the last completed transfers left behind
    logic [31:0] m_hrdata = 32'h0;
    logic [31:0] m_pwdata = 32'h0;

    // observations of one transfer
    int          o_low, o_sel, o_en;
    logic [2:0]  o_psel;
    logic        o_setup_en, o_tmo;
    logic [1:0]  o_resp_low, o_resp_end;

    // Drive one AHB transfer starting at a negedge with Hreadyout high, act as
    // the APB slave, and return at the negedge where Hreadyout is high again.
    task automatic xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic err,
                        input logic [31:0] rdata);
        int k;
        Htrans = 2'b10; Hwrite = wr; Hsize = size; Haddr = addr; Hreadyin = 1'b1;
        @(negedge Hclk);
        Htrans = 2'b00; Hwdata = wdata;
        o_low = 0; o_sel = 0; o_en = 0; o_psel = 3'b000; o_setup_en = 1'b0;
        o_resp_low = 2'b00; o_tmo = 1'b1; k = 0;
        for (int c = 0; c < 40; c++) begin
            if (Hreadyout === 1'b1) begin
                o_tmo = 1'b0;
                break;
            end
            o_low++;
            o_resp_low = Hresp;
            if (Pselx !== 3'b000) begin
                if (o_sel == 0) o_setup_en = Penable;
                o_sel++;
                o_psel = o_psel | Pselx;
            end
            if (Penable === 1'b1) begin
                Pready  = (k >= waits);
                Pslverr = err && (k >= waits);
                Prdata  = rdata;
                k++;
                o_en++;
            end else begin
                Pready = 1'b0; Pslverr = 1'b0;
            end
            @(negedge Hclk);
        end
        Pready = 1'b0; Pslverr = 1'b0;
        o_resp_end = Hresp;
    endtask

    // Behavioural model: expected outcome of one transfer from the bridge rules
    task automatic model(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic err,
                         input logic [31:0] rdata, output logic e_legal, output int e_low,
                         output int e_sel, output int e_en, output logic [2:0] e_psel,
                         output logic [1:0] e_resp, output logic [3:0] e_pstrb);
        int  idx, en;
        bit  hit, fail;
        idx     = int'((addr >> 12) & 32'd7);
        hit     = ((addr >> 15) == (32'h8000_0000 >> 15)) && (idx < 3);
        e_legal = hit && (size <= 3'd2) && ((addr % (32'd1 << size)) == 32'd0);
        if (!e_legal) begin
            e_low = 1; e_sel = 0; e_en = 0; e_psel = 3'b000; e_resp = 2'b01;
        end else begin
            if (waits >= 4) begin en = 4; fail = 1'b1; end
            else begin en = waits + 1; fail = err; end
            e_en   = en;
            e_sel  = en + 1;
            e_psel = 3'(1 << idx);
            e_low  = (wr ? 1 : 0) + 1 + en + (fail ? 1 : 0);
            e_resp = fail ? 2'b01 : 2'b00;
            if (wr) m_pwdata = wdata;
            if (!wr && !fail) m_hrdata = rdata;
        end
        if (!wr) e_pstrb = 4'b0000;
        else if (size == 3'd0) e_pstrb = 4'(1 << (addr % 4));
        else if (size == 3'd1) e_pstrb = 4'(3 << (addr % 4));
        else e_pstrb = 4'b1111;
    endtask

    task automatic test_reset();
        Hresetn = 1'b0;
        repeat (2) @(negedge Hclk);
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%b exp=1", Hreadyout); end
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL rst_hresp got=%b exp=00", Hresp); end
        total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", Hrdata); end
        total++; if ({Pselx, Penable, Pwrite, Pstrb} !== 9'h0) begin bad++;
            $display("FAIL rst_apb_ctl got=%b exp=0", {Pselx, Penable, Pwrite, Pstrb}); end
        total++; if ({Paddr, Pwdata} !== 64'h0) begin bad++; $display("FAIL rst_apb_bus got=%h exp=0", {Paddr, Pwdata}); end
        Hresetn = 1'b1;
        @(negedge Hclk);
    endtask

    task automatic test_read();
        xfer(1'b0, 3'd2, 32'h8000_1004, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        m_hrdata = 32'hDEAD_BEEF;
        total++; if (o_psel !== 3'b010 || o_sel != 2) begin bad++; $display("FAIL rd_psel got=%b/%0d exp=010/2", o_psel, o_sel); end
        total++; if (o_setup_en !== 1'b0 || o_en != 1) begin bad++; $display("FAIL rd_penable got=%b/%0d exp=0/1", o_setup_en, o_en); end
        total++; if (o_low != 2 || o_tmo) begin bad++; $display("FAIL rd_low got=%0d exp=2", o_low); end
        total++; if (Hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", Hrdata); end
        total++; if (o_resp_end !== 2'b00) begin bad++; $display("FAIL rd_resp got=%b exp=00", o_resp_end); end
    endtask

    task automatic test_byte_write();
        xfer(1'b1, 3'd0, 32'h8000_2003, 32'hAB00_0000, 0, 1'b0, 32'h0);
        m_pwdata = 32'hAB00_0000;
        total++; if (o_psel !== 3'b100) begin bad++; $display("FAIL bw_psel got=%b exp=100", o_psel); end
        total++; if (Pstrb !== 4'b1000) begin bad++; $display("FAIL bw_pstrb got=%b exp=1000", Pstrb); end
        total++; if (Pwdata !== 32'hAB00_0000) begin bad++; $display("FAIL bw_pwdata got=%h exp=ab000000", Pwdata); end
        total++; if (o_resp_end !== 2'b00 || o_low != 3) begin bad++; $display("FAIL bw_resp got=%b/%0d exp=00/3", o_resp_end, o_low); end
    endtask

    task automatic test_wait_slverr();
        xfer(1'b1, 3'd2, 32'h8000_0000, 32'h1234_5678, 3, 1'b1, 32'h0);
        m_pwdata = 32'h1234_5678;
        // WDATA + SETUP + 4 ACCESS = 6 stalled cycles, then ERR1 stalls once more
        total++; if (o_low != 7 || o_en != 4) begin bad++; $display("FAIL ws_low got=%0d/%0d exp=7/4", o_low, o_en); end
        total++; if (o_resp_low !== 2'b01 || o_resp_end !== 2'b01) begin bad++;
            $display("FAIL ws_resp got=%b/%b exp=01/01", o_resp_low, o_resp_end); end
        @(negedge Hclk);
        total++; if (Hresp !== 2'b00 || Hreadyout !== 1'b1) begin bad++;
            $display("FAIL ws_idle got=%b/%b exp=00/1", Hresp, Hreadyout); end
    endtask

    task automatic test_decode_errors();
        xfer(1'b0, 3'd2, 32'h8000_3000, 32'h0, 0, 1'b0, 32'h5555_5555);
        total++; if (o_sel != 0 || o_low != 1 || o_resp_end !== 2'b01) begin bad++;
            $display("FAIL de_noslave got=%0d/%0d/%b exp=0/1/01", o_sel, o_low, o_resp_end); end
        @(negedge Hclk);
        xfer(1'b1, 3'd1, 32'h8000_0001, 32'hFFFF_FFFF, 0, 1'b0, 32'h0);
        total++; if (o_sel != 0 || o_low != 1 || o_resp_low !== 2'b01 || o_resp_end !== 2'b01) begin bad++;
            $display("FAIL de_align got=%0d/%0d/%b exp=0/1/01", o_sel, o_low, o_resp_end); end
        total++; if (Pwdata !== m_pwdata) begin bad++; $display("FAIL de_pwdata got=%h exp=%h", Pwdata, m_pwdata); end
        @(negedge Hclk);
    endtask

    task automatic test_timeout();
        xfer(1'b0, 3'd2, 32'h8000_1000, 32'h0, 30, 1'b0, 32'h7777_7777);
        total++; if (o_en != 4 || o_sel != 5) begin bad++; $display("FAIL to_penable got=%0d/%0d exp=4/5", o_en, o_sel); end
        total++; if (o_low != 6 || o_resp_end !== 2'b01) begin bad++;
            $display("FAIL to_resp got=%0d/%b exp=6/01", o_low, o_resp_end); end
        total++; if (Pselx !== 3'b000 || Hrdata !== m_hrdata) begin bad++;
            $display("FAIL to_state got=%b/%h exp=000/%h", Pselx, Hrdata, m_hrdata); end
    endtask

    task automatic test_back_to_back();
        xfer(1'b0, 3'd2, 32'h8000_0010, 32'h0, 0, 1'b0, 32'hA5A5_0001);
        total++; if (o_low != 2 || Hrdata !== 32'hA5A5_0001) begin bad++; $display("FAIL b2b_rd0 got=%0d/%h", o_low, Hrdata); end
        xfer(1'b1, 3'd2, 32'h8000_1020, 32'hC0DE_0002, 0, 1'b0, 32'h0);
        m_pwdata = 32'hC0DE_0002;
        total++; if (o_low != 3 || Pwdata !== 32'hC0DE_0002) begin bad++; $display("FAIL b2b_wr got=%0d/%h", o_low, Pwdata); end
        xfer(1'b0, 3'd0, 32'h8000_4000, 32'h0, 0, 1'b0, 32'h0);
        total++; if (o_low != 1 || o_resp_end !== 2'b01) begin bad++; $display("FAIL b2b_err got=%0d/%b", o_low, o_resp_end); end
        // accepted during ERR2
        xfer(1'b0, 3'd2, 32'h8000_2000, 32'h0, 1, 1'b0, 32'h0BAD_F00D);
        m_hrdata = 32'h0BAD_F00D;
        total++; if (o_low != 3 || Hrdata !== 32'h0BAD_F00D || o_resp_end !== 2'b00) begin bad++;
            $display("FAIL b2b_after_err got=%0d/%h/%b exp=3/0badf00d/00", o_low, Hrdata, o_resp_end); end
    endtask

    task automatic test_reset_mid();
        Htrans = 2'b10; Hwrite = 1'b0; Hsize = 3'd2; Haddr = 32'h8000_1000; Hreadyin = 1'b1;
        @(negedge Hclk);
        Htrans = 2'b00;
        @(negedge Hclk);
        total++; if (Penable !== 1'b1) begin bad++; $display("FAIL rm_access got=%b exp=1", Penable); end
        Hresetn = 1'b0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        total++; if (Hreadyout !== 1'b1 || Hresp !== 2'b00 || Hrdata !== 32'h0) begin bad++;
            $display("FAIL rm_ahb got=%b/%b/%h exp=1/00/0", Hreadyout, Hresp, Hrdata); end
        total++; if ({Pselx, Penable, Pwrite, Pstrb, Paddr, Pwdata} !== 73'h0) begin bad++;
            $display("FAIL rm_apb got=%b/%b/%h/%h", Pselx, Penable, Paddr, Pwdata); end
        m_hrdata = 32'h0; m_pwdata = 32'h0;
        xfer(1'b0, 3'd2, 32'h8000_0004, 32'h0, 0, 1'b0, 32'h1357_9BDF);
        m_hrdata = 32'h1357_9BDF;
        total++; if (o_low != 2 || Hrdata !== 32'h1357_9BDF) begin bad++;
            $display("FAIL rm_after got=%0d/%h exp=2/13579bdf", o_low, Hrdata); end
    endtask

    task automatic test_random();
        logic        wr, err, e_legal;
        logic [2:0]  size, e_psel;
        logic [31:0] addr, wdata, rdata;
        logic [1:0]  e_resp;
        logic [3:0]  e_pstrb;
        int          waits, e_low, e_sel, e_en;
        for (int n = 0; n < 60; n++) begin
            wr    = 1'($urandom_range(0, 1));
            size  = 3'($urandom_range(0, 3));
            addr  = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 12) + 32'($urandom_range(0, 63));
            if (size <= 3'd2 && $urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 9) == 0) addr = addr ^ 32'h0001_0000;
            wdata = $urandom;
            rdata = $urandom;
            waits = $urandom_range(0, 5);
            err   = ($urandom_range(0, 7) == 0);
            model(wr, size, addr, wdata, waits, err, rdata, e_legal, e_low, e_sel, e_en, e_psel, e_resp, e_pstrb);
            xfer(wr, size, addr, wdata, waits, err, rdata);
            total++; if (o_tmo || o_low != e_low) begin bad++; $display("FAIL rnd_low n=%0d got=%0d exp=%0d", n, o_low, e_low); end
            total++; if (o_sel != e_sel || o_en != e_en || o_psel !== e_psel) begin bad++;
                $display("FAIL rnd_apb n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, o_sel, o_en, o_psel, e_sel, e_en, e_psel); end
            total++; if (o_resp_low !== e_resp || o_resp_end !== e_resp) begin bad++;
                $display("FAIL rnd_resp n=%0d got=%b/%b exp=%b", n, o_resp_low, o_resp_end, e_resp); end
            total++; if (Hrdata !== m_hrdata || Pwdata !== m_pwdata) begin bad++;
                $display("FAIL rnd_data n=%0d got=%h/%h exp=%h/%h", n, Hrdata, Pwdata, m_hrdata, m_pwdata); end
            total++; if (Paddr !== addr || Pwrite !== wr) begin bad++;
                $display("FAIL rnd_addr n=%0d got=%h/%b exp=%h/%b", n, Paddr, Pwrite, addr, wr); end
            if (e_legal) begin
                total++; if (Pstrb !== e_pstrb) begin bad++; $display("FAIL rnd_pstrb n=%0d got=%b exp=%b", n, Pstrb, e_pstrb); end
            end
            repeat ($urandom_range(0, 2)) @(negedge Hclk);
        end
    endtask

    initial begin
        Hresetn = 1'b0; Htrans = 2'b00; Hwrite = 1'b0; Hsize = 3'd0; Haddr = 32'h0;
        Hwdata = 32'h0; Hreadyin = 1'b1; Pready = 1'b0; Pslverr = 1'b0; Prdata = 32'h0;
        @(negedge Hclk);
        test_reset();
        test_read();
        test_byte_write();
        test_wait_slverr();
        test_decode_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
